// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM encoding,
// BCD digit width and the modulus of each display digit.
package stopwatch_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MOD_TENTHS = 10;
  localparam int MOD_SEC_U  = 10;
  localparam int MOD_SEC_T  = 6;
  localparam int MOD_MIN    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One modulo-MOD counting digit; carry flags the enabled wrap so the next
// digit up can use it directly as its enable.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic at_max;

  assign at_max = (q == DIGIT_W'(MOD - 1));
  assign carry  = en && at_max;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= at_max ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM, tenth-second prescaler,
// M:SS.T digit chain with sticky overflow and a lap-hold display register.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_stop,
  input  logic               lap,
  input  logic               clear,
  output logic [DIGIT_W-1:0] disp_tenths,
  output logic [DIGIT_W-1:0] disp_sec_u,
  output logic [DIGIT_W-1:0] disp_sec_t,
  output logic [DIGIT_W-1:0] disp_min,
  output logic               running,
  output logic               lap_active,
  output logic               ovf
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t state, next_state;

  logic [PW-1:0]      presc;
  logic               counting;
  logic               tick;
  logic               entering_lap;
  logic [DIGIT_W-1:0] q_tenths, q_sec_u, q_sec_t, q_min;
  logic               c_tenths, c_sec_u, c_sec_t, c_min;
  logic [DIGIT_W-1:0] lap_tenths, lap_sec_u, lap_sec_t, lap_min;

  assign counting     = (state == RUN) || (state == LAP);
  assign tick         = counting && (presc == PW'(TICK_DIV - 1));
  assign entering_lap = (next_state == LAP) && (state != LAP);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Priority clear > start_stop > lap; losing commands are simply dropped.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else if (start_stop) begin
      unique case (state)
        IDLE:    next_state = RUN;
        RUN:     next_state = PAUSE;
        PAUSE:   next_state = RUN;
        LAP:     next_state = PAUSE;
        default: next_state = IDLE;
      endcase
    end else if (lap) begin
      if (state == RUN) begin
        next_state = LAP;
      end else if (state == LAP) begin
        next_state = RUN;
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (clear || (state == IDLE)) begin
      presc <= '0;
    end else if (counting) begin
      presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
    end
  end

  bcd_digit #(.MOD(MOD_TENTHS)) u_tenths (
    .clk(clk), .rst(rst), .clr(clear), .en(tick),     .q(q_tenths), .carry(c_tenths)
  );
  bcd_digit #(.MOD(MOD_SEC_U)) u_sec_u (
    .clk(clk), .rst(rst), .clr(clear), .en(c_tenths), .q(q_sec_u),  .carry(c_sec_u)
  );
  bcd_digit #(.MOD(MOD_SEC_T)) u_sec_t (
    .clk(clk), .rst(rst), .clr(clear), .en(c_sec_u),  .q(q_sec_t),  .carry(c_sec_t)
  );
  bcd_digit #(.MOD(MOD_MIN)) u_min (
    .clk(clk), .rst(rst), .clr(clear), .en(c_sec_t),  .q(q_min),    .carry(c_min)
  );

  // The snapshot takes the digits as they stood before this edge's tick.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      lap_tenths <= '0;
      lap_sec_u  <= '0;
      lap_sec_t  <= '0;
      lap_min    <= '0;
    end else if (clear) begin
      lap_tenths <= '0;
      lap_sec_u  <= '0;
      lap_sec_t  <= '0;
      lap_min    <= '0;
    end else if (entering_lap) begin
      lap_tenths <= q_tenths;
      lap_sec_u  <= q_sec_u;
      lap_sec_t  <= q_sec_t;
      lap_min    <= q_min;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (clear) begin
      ovf <= 1'b0;
    end else if (c_min) begin
      ovf <= 1'b1;
    end
  end

  assign running     = counting;
  assign lap_active  = (state == LAP);
  assign disp_tenths = lap_active ? lap_tenths : q_tenths;
  assign disp_sec_u  = lap_active ? lap_sec_u  : q_sec_u;
  assign disp_sec_t  = lap_active ? lap_sec_t  : q_sec_t;
  assign disp_min    = lap_active ? lap_min    : q_min;

endmodule
